// File: rtl/id_issue_arbiter_if.sv
// Request/issue bus of the ID issue arbiter: requester handshakes on one side,
// issued ID strobe and FIFO occupancy on the other.
interface id_issue_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 4,
    parameter int DEPTH = 4
);
    logic                         issue_en;
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ*ID_W-1:0]        req_id;
    logic [N_REQ-1:0]             req_ready;
    logic [ID_W-1:0]              id_sel;
    logic                         id_ok;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;

    // master: the requesters plus the downstream stage; slave: the arbiter
    modport master (
        output issue_en, req_valid, req_id,
        input  req_ready, id_sel, id_ok, fifo_count
    );

    modport slave (
        input  issue_en, req_valid, req_id,
        output req_ready, id_sel, id_ok, fifo_count
    );
endinterface

// File: rtl/id_issue_arbiter.sv
// Round-robin collector of requester IDs into a small FIFO, issuing one ID per
// id_ok strobe with a programmable idle gap after every issue.
module id_issue_arbiter #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int GAP   = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    id_issue_arbiter_if.slave    bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int RR_W  = $clog2(N_REQ);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [RR_W-1:0]  rr_ptr_q,     rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [GAP_W-1:0] gap_cnt_q,    gap_cnt_d;
    logic [ID_W-1:0]  id_sel_q,     id_sel_d;
    logic             id_ok_q,      id_ok_d;
    logic [ID_W-1:0]  fifo_q [DEPTH];
    logic [ID_W-1:0]  fifo_d [DEPTH];

    logic             grant_vld;
    logic [RR_W-1:0]  grant_idx;
    logic [N_REQ-1:0] grant_oh;
    logic [N_REQ-1:0] req_ready;
    logic             not_full;
    logic             push;
    logic             pop;
    logic [ID_W-1:0]  push_id;
    int               cand;

    // Search for the first valid requester starting at rr_ptr, wrapping mod N_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_vld && bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(cand);
            end
        end
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign not_full  = (fifo_count_q < CNT_W'(DEPTH));
    assign req_ready = grant_oh & {N_REQ{not_full & resetn}};
    assign push      = |(bus.req_valid & req_ready);
    assign push_id   = bus.req_id[grant_idx*ID_W +: ID_W];
    assign pop       = (fifo_count_q != '0) && bus.issue_en && (gap_cnt_q == '0);

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        gap_cnt_d    = gap_cnt_q;
        id_sel_d     = id_sel_q;
        id_ok_d      = 1'b0;
        fifo_d       = fifo_q;

        if (push) begin
            fifo_d[wr_ptr_q] = push_id;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            rr_ptr_d         = (grant_idx == RR_W'(N_REQ - 1)) ? '0 : grant_idx + RR_W'(1);
        end

        // The gap counter only runs down while no issue takes place.
        if (pop) begin
            id_sel_d  = fifo_q[rd_ptr_q];
            id_ok_d   = 1'b1;
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            gap_cnt_d = GAP_W'(GAP);
        end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            gap_cnt_q    <= '0;
            id_sel_q     <= '0;
            id_ok_q      <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            gap_cnt_q    <= gap_cnt_d;
            id_sel_q     <= id_sel_d;
            id_ok_q      <= id_ok_d;
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is live.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign bus.req_ready  = req_ready;
    assign bus.id_sel     = id_sel_q;
    assign bus.id_ok      = id_ok_q;
    assign bus.fifo_count = fifo_count_q;

    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

    generate
        if (GAP > 0) begin : g_gap_chk
            a_no_back_to_back: assert property (@(posedge clk) disable iff (!resetn)
                id_ok_q |=> !id_ok_q);
        end
    endgenerate

endmodule
